axi_stream_wr_master: RTL and testbench

// Write-only AXI4 master that sits directly upstream of an AXI4 slave memory
// (e.g. the team's AXI RAM). Accepts a write descriptor (address, beat count) and
// an untagged data stream, then issues full-width INCR bursts.

---
 rtl/axi_stream_wr_master.sv | 164 ++++++++++++++++
 tb/tb_axi_stream_wr_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_wr_master.sv
// rtl/axi_stream_wr_master.sv - descriptor-driven AXI4 write master fed by a data stream
// Splits each descriptor into INCR bursts bounded by MAX_BURST_LEN and 4 KB pages.
module axi_stream_wr_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [LEN_WIDTH-1:0]  s_desc_len,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [1:0]            m_status_error,
  output logic                  m_status_valid,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SIZE = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [8:0]            beats_q;
  logic [7:0]            cnt;
  logic [1:0]            err;
  logic [1:0]            err_max;
  logic [31:0]           rem_w;
  logic [31:0]           bnd_w;
  logic [31:0]           beats_w;
  logic                  in_data;
  logic                  unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;

  // W channel is a straight pass-through of the stream while a burst is open
  assign in_data       = (state == DATA);
  assign m_axi_wvalid  = in_data & s_axis_tvalid;
  assign s_axis_tready = in_data & m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = in_data && (cnt == '0);

  assign err_max = (m_axi_bresp > err) ? m_axi_bresp : err;

  // Beats left before the aligned address reaches the next 4 KB page
  always_comb begin
    rem_w   = 32'(remaining);
    bnd_w   = (32'd4096 - {20'd0, addr_q[11:0]}) >> SIZE;
    beats_w = rem_w;
    if (beats_w > 32'(MAX_BURST_LEN)) beats_w = 32'(MAX_BURST_LEN);
    if (beats_w > bnd_w) beats_w = bnd_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      s_desc_ready   <= 1'b0;
      m_axi_awvalid  <= 1'b0;
      m_axi_awaddr   <= '0;
      m_axi_awlen    <= '0;
      m_axi_bready   <= 1'b0;
      m_status_valid <= 1'b0;
      m_status_error <= 2'b00;
      err            <= 2'b00;
      addr_q         <= '0;
      remaining      <= '0;
      beats_q        <= '0;
      cnt            <= '0;
    end else begin
      m_status_valid <= 1'b0;
      case (state)
        IDLE: begin
          s_desc_ready <= 1'b1;
          if (s_desc_valid && s_desc_ready) begin
            s_desc_ready <= 1'b0;
            addr_q       <= s_desc_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            remaining    <= s_desc_len;
            err          <= 2'b00;
            if (s_desc_len == '0) begin
              m_status_valid <= 1'b1;
              m_status_error <= 2'b00;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (!m_axi_awvalid) begin
            m_axi_awaddr  <= addr_q;
            m_axi_awlen   <= 8'(beats_w - 32'd1);
            beats_q       <= 9'(beats_w);
            m_axi_awvalid <= 1'b1;
          end else if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            addr_q        <= addr_q + ADDR_WIDTH'(32'(beats_q) << SIZE);
            remaining     <= remaining - LEN_WIDTH'(beats_q);
            cnt           <= m_axi_awlen;
            state         <= DATA;
          end
        end
        DATA: begin
          if (m_axi_wvalid && m_axi_wready) begin
            if (cnt == '0) begin
              state        <= RESP;
              m_axi_bready <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            err          <= err_max;
            if (remaining != '0) begin
              state <= ADDR;
            end else begin
              m_status_valid <= 1'b1;
              m_status_error <= err_max;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_wr_master.sv
// tb/tb_axi_stream_wr_master.sv - scoreboard bench with a stalling AXI slave memory model
module tb_axi_stream_wr_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_desc_addr = '0;
  logic [15:0] s_desc_len = '0;
  logic        s_desc_valid = 1'b0;
  logic        s_desc_ready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [1:0]  m_status_error;
  logic        m_status_valid;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clk = ~clk;

  axi_stream_wr_master dut (
    .clk(clk), .rst(rst),
    .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_status_error(m_status_error), .m_status_valid(m_status_valid),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [23:0] exp_aw[$];
  logic [32:0] exp_w[$];
  logic [1:0]  exp_st[$];
  logic [31:0] src_q[$];
  logic [1:0]  bresp_plan[$];
  logic [1:0]  b_resp_q[$];
  logic [23:0] aw_log[$];
  logic [15:0] rb_addr[$];
  logic [31:0] rb_data[$];
  logic [31:0] mem [0:16383];
  logic [15:0] wr_addr = '0;
  logic [23:0] e_aw;
  logic [32:0] e_w;
  int          stall_pct = 0;
  int          b_pend = 0;
  int          b_count = 0;
  int          st_b_count = -1;
  logic        b_fire = 1'b0;

  // Slave + source model: drive at negedge, resolve the handshakes that the next posedge will see
  always @(negedge clk) begin
    m_axi_awready = ($urandom_range(0, 99) >= stall_pct);
    m_axi_wready  = ($urandom_range(0, 99) >= stall_pct);
    if (src_q.size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0];
    end else begin
      s_axis_tvalid = 1'b0;
    end
    if (b_fire) m_axi_bvalid = 1'b0;
    b_fire = 1'b0;
    if (!m_axi_bvalid && b_pend > 0 && b_resp_q.size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = b_resp_q[0];
    end
    #1;
    if (rst) begin
      m_axi_bvalid  = 1'b0;
      s_axis_tvalid = 1'b0;
      b_pend        = 0;
      b_resp_q.delete();
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        check_val("aw_pending", exp_aw.size() > 0, 1);
        if (exp_aw.size() > 0) begin
          e_aw = exp_aw.pop_front();
          check_val("awaddr", m_axi_awaddr, e_aw[23:8]);
          check_val("awlen", m_axi_awlen, e_aw[7:0]);
        end
        aw_log.push_back({m_axi_awaddr, m_axi_awlen});
        wr_addr = m_axi_awaddr;
        if (bresp_plan.size() > 0) b_resp_q.push_back(bresp_plan.pop_front());
        else b_resp_q.push_back(2'b00);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        check_val("w_pending", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) begin
          e_w = exp_w.pop_front();
          check_val("wdata", m_axi_wdata, e_w[31:0]);
          check_val("wlast", m_axi_wlast, e_w[32]);
        end
        mem[wr_addr[15:2]] = m_axi_wdata;
        wr_addr = wr_addr + 16'd4;
        if (m_axi_wlast) b_pend++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_fire = 1'b1;
        b_pend--;
        b_count++;
        void'(b_resp_q.pop_front());
      end
      if (m_status_valid) begin
        check_val("status_pending", exp_st.size() > 0, 1);
        if (exp_st.size() > 0) check_val("status_err", m_status_error, exp_st.pop_front());
        st_b_count = b_count;
      end
    end
  end

  // Independent burst-split model: fills the AW, W, status and readback expectations
  task automatic plan_desc(input logic [15:0] a0, input int len, input logic [31:0] base,
                           input logic [1:0] err);
    logic [15:0] a;
    int rem, b, room, k;
    logic [31:0] d;
    a = a0 & 16'hFFFC;
    rem = len;
    k = 0;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_aw.push_back({a, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        d = base + 32'(k);
        k++;
        exp_w.push_back({(i == b - 1), d});
        src_q.push_back(d);
        rb_addr.push_back(a + 16'(i * 4));
        rb_data.push_back(d);
      end
      a = a + 16'(b * 4);
      rem -= b;
    end
    exp_st.push_back(err);
  endtask

  task automatic drive_desc(input logic [15:0] a, input logic [15:0] len);
    int n;
    n = 0;
    @(negedge clk);
    s_desc_addr  = a;
    s_desc_len   = len;
    s_desc_valid = 1'b1;
    while (!s_desc_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("desc_accept", s_desc_ready, 1);
    @(negedge clk);
    s_desc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic [15:0] ra;
    logic [31:0] rd;
    n = 0;
    while (exp_st.size() > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_status_done"}, exp_st.size(), 0);
    check_val({tag, "_aw_left"}, exp_aw.size(), 0);
    check_val({tag, "_w_left"}, exp_w.size(), 0);
    while (rb_addr.size() > 0) begin
      ra = rb_addr.pop_front();
      rd = rb_data.pop_front();
      check_val({tag, "_readback"}, mem[ra[15:2]], rd);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_val("rst_desc_ready", s_desc_ready, 0);
    check_val("rst_awvalid", m_axi_awvalid, 0);
    check_val("rst_wvalid", m_axi_wvalid, 0);
    check_val("rst_tready", s_axis_tready, 0);
    check_val("rst_bready", m_axi_bready, 0);
    check_val("rst_status_valid", m_status_valid, 0);
    check_val("awsize", m_axi_awsize, 2);
    check_val("awburst", m_axi_awburst, 1);
    check_val("awcache", m_axi_awcache, 3);
    check_val("wstrb", m_axi_wstrb, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", s_desc_ready, 1);

    // 1: single short burst with fixed data
    aw_log.delete();
    plan_desc(16'h0100, 4, 32'hA0, 2'b00);
    drive_desc(16'h0100, 16'd4);
    wait_done("t1");
    check_val("t1_aw", aw_log[0], {16'h0100, 8'd3});
    check_val("t1_mem_last", mem[16'h010C >> 2], 32'hA3);

    // 2: length split into 16+16+8, one status after the third B
    aw_log.delete();
    b_count = 0;
    plan_desc(16'h0000, 40, $urandom, 2'b00);
    drive_desc(16'h0000, 16'd40);
    wait_done("t2");
    check_val("t2_aw_count", aw_log.size(), 3);
    check_val("t2_aw1", aw_log[1], {16'h0040, 8'd15});
    check_val("t2_aw2", aw_log[2], {16'h0080, 8'd7});
    check_val("t2_status_after_b3", st_b_count, 3);

    // 3: 4 KB boundary split
    aw_log.delete();
    plan_desc(16'h0FF8, 8, $urandom, 2'b00);
    drive_desc(16'h0FF8, 16'd8);
    wait_done("t3");
    check_val("t3_aw0", aw_log[0], {16'h0FF8, 8'd1});
    check_val("t3_aw1", aw_log[1], {16'h1000, 8'd5});

    // 4: zero-length descriptor
    aw_log.delete();
    plan_desc(16'h0200, 0, 32'h0, 2'b00);
    drive_desc(16'h0200, 16'd0);
    check_val("t4_pulse", m_status_valid, 1);
    @(negedge clk);
    check_val("t4_pulse_end", m_status_valid, 0);
    wait_done("t4");
    check_val("t4_no_aw", aw_log.size(), 0);

    // 5: random stalls and SLVERR on the second burst
    stall_pct = 35;
    bresp_plan.delete();
    bresp_plan.push_back(2'b00);
    bresp_plan.push_back(2'b10);
    plan_desc(16'h0400, 32, $urandom, 2'b10);
    drive_desc(16'h0402, 16'd32);
    wait_done("t5");
    stall_pct = 0;

    // 6: reset while data is flowing, then a clean descriptor
    plan_desc(16'h0800, 16, $urandom, 2'b00);
    drive_desc(16'h0800, 16'd16);
    n = 0;
    while (!m_axi_wvalid && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_val("t6_in_data", m_axi_wvalid, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_aw.delete();
    exp_w.delete();
    exp_st.delete();
    src_q.delete();
    rb_addr.delete();
    rb_data.delete();
    @(negedge clk);
    check_val("t6_awvalid", m_axi_awvalid, 0);
    check_val("t6_wvalid", m_axi_wvalid, 0);
    check_val("t6_bready", m_axi_bready, 0);
    check_val("t6_desc_ready_in_rst", s_desc_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("t6_desc_ready", s_desc_ready, 1);
    plan_desc(16'h0900, 5, $urandom, 2'b00);
    drive_desc(16'h0900, 16'd5);
    wait_done("t6");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
